// File: rtl/uart_rx_port_pkg.sv
// Shared definitions for the UART ports: FSM state encodings and status bit
// positions. Kept separate so a future transmitter can reuse them.
package uart_rx_port_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Bit positions inside the 8-bit status word read by the CPU.
    localparam int unsigned ST_VALID = 0;
    localparam int unsigned ST_OVR   = 1;
    localparam int unsigned ST_FERR  = 2;
    localparam int unsigned ST_BUSY  = 3;

    // Assemble the status word; the upper nibble is always zero.
    function automatic logic [7:0] pack_status(input logic busy, input logic ferr,
                                               input logic ovr, input logic valid);
        logic [7:0] s;
        s           = '0;
        s[ST_BUSY]  = busy;
        s[ST_FERR]  = ferr;
        s[ST_OVR]   = ovr;
        s[ST_VALID] = valid;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the receiver: two-flop synchroniser on the
// asynchronous serial line and a rising-edge detector on the CPU ack bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic ack,
    output logic rx_s,
    output logic ack_rise
);

    logic rx_meta;
    logic ack_q;

    // Synchronise rx and remember last cycle's ack level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the line idles high, so the synchroniser resets to 1; resetting to 0
            // would look like a start bit the moment reset is released.
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here make rx_meta -> rx_s a real
            // two-stage pipeline; blocking ones would collapse it to a single flop.
            rx_meta <= rx;
            rx_s    <= rx_meta;
            ack_q   <= ack;
        end
    end

    // ack comes from a synchronous CPU output port, so it is used directly.
    assign ack_rise = ack & ~ack_q;

endmodule

// File: rtl/uart_rx_port.sv
// Polled 8N1 UART receiver. rx_data feeds a CPU input port with the last
// good byte; rx_status reports {4'b0, busy, ferr, ovr, valid}. The CPU
// acknowledges a byte with a rising edge on ack.
module uart_rx_port
    import uart_rx_port_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] rx_data,
    output logic [7:0] rx_status
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_s;
    logic             ack_rise;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             valid;
    logic             ovr;
    logic             ferr;
    logic             busy;

    uart_rx_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .ack      (ack),
        .rx_s     (rx_s),
        .ack_rise (ack_rise)
    );

    // Frame reception, byte commit and status flag bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            // NOTE: the shift register is plain datapath, but it is cheap and resetting
            // it keeps a partially received byte from surviving an aborted frame.
            shift   <= '0;
            rx_data <= '0;
            valid   <= 1'b0;
            ovr     <= 1'b0;
            ferr    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // NOTE: the acknowledge clear is written first on purpose; a commit or framing
            // error later in this block overrides it because the last non-blocking
            // assignment to a register in the same edge wins.
            if (ack_rise) begin
                valid <= 1'b0;
                ovr   <= 1'b0;
                ferr  <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                RX_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end else begin
                            // Start bit did not hold to mid-bit: treat it as a glitch.
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                            // An unread byte is never overwritten unless the CPU
                            // acknowledges it in this very cycle.
                            if (!valid || ack_rise) begin
                                rx_data <= shift;
                                valid   <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end else begin
                            state <= RX_BREAK;
                            ferr  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_BREAK: begin
                    // A line held low must return high before a new frame may start.
                    if (rx_s) begin
                        state <= RX_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Status word is a pure rewiring of registered flags.
    assign rx_status = pack_status(busy, ferr, ovr, valid);

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port. A behavioural model of the CPU-visible
// state pushes the expected {rx_data, rx_status without busy} into a queue
// whenever it changes; a monitor pops and compares whenever the DUT outputs change.
`timescale 1ns/1ps
module tb_uart_rx_port;

    localparam int CPB        = 8;
    // Edges from the stop-bit start to the commit edge: two synchroniser
    // flops, idle detection, then the half-bit start offset.
    localparam int COMMIT_DLY = 3 + CPB / 2;
    // Start edge to visible valid, with slack for idle detection and output register.
    localparam int LAT_MAX    = 2 + (19 * CPB) / 2 + 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ack   = 1'b0;
    logic [7:0] rx_data;
    logic [7:0] rx_status;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned last_change_cyc = 0;
    bit          mon_en   = 1'b0;
    logic [15:0] exp_q[$];

    // Reference model of what the CPU can see.
    logic [7:0]  m_data  = 8'h00;
    bit          m_valid = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_ferr  = 1'b0;
    logic [15:0] m_last  = 16'h0000;

    uart_rx_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .ack       (ack),
        .rx_data   (rx_data),
        .rx_status (rx_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_key();
        return {m_data, 5'b0, m_ferr, m_ovr, m_valid};
    endfunction

    task automatic model_push();
        logic [15:0] k;
        k = model_key();
        if (k != m_last) begin
            exp_q.push_back(k);
            m_last = k;
        end
    endtask

    // A completed frame; ack_same means the CPU acknowledged in the commit cycle.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack_same);
        if (stop_ok) begin
            if (!m_valid || ack_same) begin
                m_data  = b;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            if (ack_same) begin
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
        end else begin
            m_ferr = 1'b1;
        end
        model_push();
    endtask

    task automatic model_ack();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        model_push();
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        model_push();
    endtask

    // Drive one 8N1 frame. hold_low: extra low cycles after a bad stop bit.
    // ack_at: stop-bit cycle at which ack rises (-1 none). rst_bit: data bit
    // during which reset is pulsed (-1 none); the rest of that frame is idle-high.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low,
                              input int ack_at, input int rst_bit,
                              output int unsigned start_cyc);
        bit aborted;
        aborted = 1'b0;
        @(negedge clk);
        rx        = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = aborted ? 1'b1 : b[i];
            if (i == rst_bit) begin
                aborted = 1'b1;
                rx      = 1'b1;
                model_reset();
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("reset_data_zero", 32'(rx_data), 32'h0);
                check("reset_status_zero", 32'(rx_status), 32'h0);
                @(negedge clk);
                reset = 1'b0;
                repeat (CPB - 3) @(negedge clk);
            end else begin
                if (i == 4 && !aborted) check("busy_mid_frame", 32'(rx_status[3]), 32'h1);
                repeat (CPB) @(negedge clk);
            end
        end
        rx = aborted ? 1'b1 : stop_ok;
        if (!aborted) model_frame(b, stop_ok, ack_at >= 0);
        for (int j = 1; j <= CPB; j++) begin
            @(negedge clk);
            if (j == ack_at) ack = 1'b1;
        end
        if (!aborted && !stop_ok) begin
            for (int j = 0; j < hold_low; j++) begin
                if (hold_low >= 10 && j == hold_low / 2)
                    check("break_status", 32'(rx_status),
                          32'({4'h0, 1'b1, m_ferr, m_ovr, m_valid}));
                @(negedge clk);
            end
            rx = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        model_ack();
        repeat (3) @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic [7:0] s);
        check({name, "_data"}, 32'(rx_data), 32'(d));
        check({name, "_status"}, 32'(rx_status), 32'(s));
    endtask

    // Scoreboard monitor: every change of the CPU-visible state must match
    // the next model prediction, in order.
    initial begin
        logic [15:0] prev;
        logic [15:0] cur;
        wait (mon_en);
        @(negedge clk);
        prev = {rx_data, rx_status & 8'hF7};
        forever begin
            @(negedge clk);
            cur = {rx_data, rx_status & 8'hF7};
            if (cur !== prev) begin
                last_change_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: got %h, expected no change from %h", cur, prev);
                end else begin
                    check("scoreboard_update", 32'(cur), 32'(exp_q.pop_front()));
                end
                prev = cur;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s;
        logic [7:0]  b;
        int          kind;

        // Reset state.
        repeat (3) @(negedge clk);
        expect_out("reset_hold", 8'h00, 8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("after_reset", 8'h00, 8'h00);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte, no ack.
        send_frame(8'hA5, 1'b1, 0, -1, -1, s);
        expect_out("t1_a5", 8'hA5, 8'h01);
        check("t1_latency_bound", 32'((last_change_cyc - s) <= LAT_MAX), 32'h1);
        check("t1_not_early", 32'((last_change_cyc - s) > 9 * CPB), 32'h1);
        ack_pulse();

        // 2: overrun keeps the unread byte; ack clears everything.
        send_frame(8'h3C, 1'b1, 0, -1, -1, s);
        send_frame(8'hC3, 1'b1, 0, -1, -1, s);
        expect_out("t2_overrun", 8'h3C, 8'h03);
        ack_pulse();
        expect_out("t2_ack", 8'h3C, 8'h00);

        // 3: framing error with line held low, then a good byte.
        send_frame(8'h55, 1'b0, 30, -1, -1, s);
        expect_out("t3_ferr", 8'h3C, 8'h04);
        send_frame(8'h12, 1'b1, 0, -1, -1, s);
        expect_out("t3_after_break", 8'h12, 8'h05);
        ack_pulse();

        // 4: short glitch on the idle line.
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_glitch_busy", 32'(rx_status), 32'h08);
        repeat (10) @(negedge clk);
        check("t4_glitch_idle", 32'(rx_status), 32'h00);

        // 5: ack rising exactly on the commit edge while a byte is pending.
        b = 8'($urandom);
        send_frame(b, 1'b1, 0, -1, -1, s);
        send_frame(8'h7E, 1'b1, 0, COMMIT_DLY - 1, -1, s);
        expect_out("t5_ack_commit", 8'h7E, 8'h01);
        ack = 1'b0;
        repeat (2) @(negedge clk);

        // 6: reset in the middle of a frame, then a fresh byte.
        send_frame(8'hFF, 1'b1, 0, -1, 4, s);
        send_frame(8'h81, 1'b1, 0, -1, -1, s);
        expect_out("t6_after_reset", 8'h81, 8'h01);

        // 7: ack held high clears only once.
        @(negedge clk);
        ack = 1'b1;
        model_ack();
        repeat (3) @(negedge clk);
        send_frame(8'h99, 1'b1, 0, -1, -1, s);
        send_frame(8'h66, 1'b1, 0, -1, -1, s);
        expect_out("t7_ack_level", 8'h99, 8'h03);
        ack = 1'b0;
        ack_pulse();

        // Random traffic: good and bad frames, random acks and gaps.
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind < 8) send_frame(b, 1'b1, 0, -1, -1, s);
            else          send_frame(b, 1'b0, int'($urandom_range(2, 12)), -1, -1, s);
            check("rand_status", 32'(rx_status), 32'({4'h0, 1'b0, m_ferr, m_ovr, m_valid}));
            if ($urandom_range(0, 1) == 1) ack_pulse();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
